flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares the SPI flash word reader between the instruction-fetch port (ibus) and the data-load port (dbus).
- Sequences the reader's strobe/stop handshake and arbitrates round-robin between the two ports.
- Can keep a read stream open so that sequential words are served without re-sending the 32-bit read command.
- Sits between the CPU bus ports and the flash reader peripheral.

Parameters:
- STREAM_MAX, 64: words served from one open stream before it is forcibly closed; 0 = unlimited.
- PRIO_D_INIT, 1: round-robin pointer after reset; 1 = dbus wins the first tie.

Ports:
- clk  in  1  clock
- rst  in  1  reset; also drives the reader's reset
- i_req  in  1  ibus request; held until i_ack
- i_addr  in  22  ibus byte address; bits[1:0] ignored; stable while i_req
- i_ack  out  1  one-cycle pulse; rdata valid in the same cycle
- d_req  in  1  dbus request; same rules as i_req
- d_addr  in  22  dbus byte address
- d_ack  out  1  one-cycle pulse
- rdata  out  32  read word; held until the next ack
- fl_rd_strb  out  1  start a read at fl_addr; one-cycle pulse, issued only while fl_ready=1
- fl_stop  out  1  end the stream; one-cycle pulse
- fl_addr  out  22  read address to the reader
- fl_data  in  32  word from the reader; valid when fl_valid=1
- fl_ready  in  1  reader idle
- fl_valid  in  1  one-cycle pulse per received word; repeats every 32 clk while the stream stays open

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs = 0. State = IDLE. Stream closed. Round-robin pointer = PRIO_D_INIT.
- Arbitration happens in IDLE, and in STREAM when a request matches neither continuation condition.
  - Both ports requesting: pointer side wins; the pointer then flips to the other side.
  - Single requester: it wins.
- IDLE:
  - Winner chosen and fl_ready=1: pulse fl_rd_strb, fl_addr = {addr[21:2],2'b00}, latch cur_addr and port, go to WAIT.
  - fl_ready=0: stay in IDLE.
- WAIT:
  - On fl_valid: rdata <= fl_data, pulse the granted ack the next cycle, set word_cnt = 1.
  - Then go to STREAM (PREFETCH_EN) or to STOP.
- STREAM:
  - next_addr = cur_addr + 4.
  - A request (either port, round-robin if both) with addr[21:2] == next_addr[21:2]: wait for fl_valid, deliver, cur_addr <= next_addr, word_cnt++.
  - Any non-matching request: go to STOP.
- STOP:
  - Pulse fl_stop one cycle, then wait for fl_ready=1.
  - Then go to IDLE; re-arbitration happens there.
- Minimum latency from request to ack, new stream: 1 (strobe) + 32 (command) + 32 (data) + 2 = 67 clk.
- Latency for a sequential hit: at most 32 clk after the previous word.
- Ack rule: at most one ack per cycle; i_ack and d_ack are never both high.
- Boundaries:
  - cur_addr[21:2] == all-ones: no continuation (the flash would not wrap to 0); the stream closes.
  - word_cnt == STREAM_MAX (STREAM_MAX != 0): the stream closes after that word.
  - A requester dropping req before ack is illegal; behaviour is unspecified.
  - rst mid-stream: fl_stop is not issued; the shared rst returns the reader to idle.

Optional Feature:
- PREFETCH_BUF_EN defined:
  - STREAM mode enabled.
  - One-word prefetch buffer: an fl_valid arriving in STREAM with no matching request is captured with its address.
  - A later matching request is acked in 1 clk from the buffer; the stream keeps running.
  - A second unclaimed fl_valid, or a non-matching request while the buffer is full: go to STOP and discard the buffer.
- Not defined:
  - STREAM and the buffer are removed.
  - Every access is IDLE -> WAIT -> STOP -> IDLE.

Test Plan:
- Single ibus read of 0x000104, fl_data=0xDEADBEEF:
  - fl_rd_strb with fl_addr=0x000104.
  - i_ack with rdata=0xDEADBEEF.
  - Without PREFETCH_BUF_EN: fl_stop follows.
- i_req and d_req asserted in the same cycle after reset:
  - dbus served first, then ibus.
  - Repeat the tie: ibus now wins (pointer alternates).
- PREFETCH_BUF_EN, ibus reads 0x100, 0x104, 0x108 back-to-back:
  - One fl_rd_strb only.
  - Acks spaced 32 clk apart.
  - No fl_stop until the 0x200 request.
- PREFETCH_BUF_EN, read 0x3FFFFC:
  - Stream closes (fl_stop) right after the ack.
  - A next request to 0x000000 issues a new fl_rd_strb.
- STREAM_MAX=4, sequential reads 0x0..0x10:
  - fl_stop after the 4th word.
  - The 5th word gets a fresh fl_rd_strb with fl_addr=0x10.
- rst pulsed while in WAIT:
  - All outputs 0 next cycle.
  - A subsequent d_req at 0x40 completes normally with a fresh strobe.

Source files
------------

// File: rtl/flash_arbiter_if.sv
// CPU-side request ports and SPI flash reader handshake shared by the flash arbiter.
// The arbiter uses the slave modport; whatever drives the CPU ports and the reader uses master.
interface flash_arbiter_if;
    logic        i_req;
    logic [21:0] i_addr;
    logic        i_ack;
    logic        d_req;
    logic [21:0] d_addr;
    logic        d_ack;
    logic [31:0] rdata;
    logic        fl_rd_strb;
    logic        fl_stop;
    logic [21:0] fl_addr;
    logic [31:0] fl_data;
    logic        fl_ready;
    logic        fl_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, fl_data, fl_ready, fl_valid,
        output i_ack, d_ack, rdata, fl_rd_strb, fl_stop, fl_addr
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, fl_data, fl_ready, fl_valid,
        input  i_ack, d_ack, rdata, fl_rd_strb, fl_stop, fl_addr
    );
endinterface

// File: rtl/flash_arbiter.sv
// Round-robin sharing of the SPI flash word reader between ibus and dbus.
// Define PREFETCH_BUF_EN to keep read streams open with a one-word prefetch buffer.
module flash_arbiter #(
    parameter int unsigned STREAM_MAX  = 64,
    parameter bit          PRIO_D_INIT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    flash_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
`ifdef PREFETCH_BUF_EN
        S_STREAM,
`endif
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(STREAM_MAX);

    state_t      state_q, state_d;
    logic        prio_d_q, prio_d_d;
    logic        port_d_q, port_d_d;
    logic [21:0] cur_addr_q, cur_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        strb_q, strb_d;
    logic        stop_q, stop_d;
    logic        close;

    // A port is ignored while its own ack is high so a held req is not re-served.
    logic        i_rq, d_rq, win_d, win_tie;
    logic [21:0] win_addr;
    assign i_rq     = bus.i_req & ~i_ack_q;
    assign d_rq     = bus.d_req & ~d_ack_q;
    assign win_d    = d_rq & (~i_rq | prio_d_q);
    assign win_tie  = i_rq & d_rq;
    assign win_addr = win_d ? bus.d_addr : bus.i_addr;

    logic unused_ok;
    assign unused_ok = ^{bus.i_addr[1:0], bus.d_addr[1:0], CNT_MAX};

`ifdef PREFETCH_BUF_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [21:0] next_addr;
    logic        i_hit, d_hit, hit_any, hit_d, hit_tie, other_req, last_word;
    logic        deliver;
    logic [31:0] deliver_data;

    // The buffered word always belongs to next_addr, so no separate address is stored.
    assign next_addr = cur_addr_q + 22'd4;
    assign i_hit     = i_rq && (bus.i_addr[21:2] == next_addr[21:2]);
    assign d_hit     = d_rq && (bus.d_addr[21:2] == next_addr[21:2]);
    assign hit_any   = i_hit | d_hit;
    assign hit_d     = d_hit & (~i_hit | prio_d_q);
    assign hit_tie   = i_hit & d_hit;
    assign other_req = (i_rq | d_rq) & ~hit_any;
    assign last_word = (next_addr[21:2] == '1) ||
                       ((STREAM_MAX != 0) && (word_cnt_q + 16'd1 == CNT_MAX));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_d_q    <= PRIO_D_INIT;
            port_d_q    <= 1'b0;
            cur_addr_q  <= '0;
            rdata_q     <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            strb_q      <= 1'b0;
            stop_q      <= 1'b0;
`ifdef PREFETCH_BUF_EN
            word_cnt_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prio_d_q    <= prio_d_d;
            port_d_q    <= port_d_d;
            cur_addr_q  <= cur_addr_d;
            rdata_q     <= rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            strb_q      <= strb_d;
            stop_q      <= stop_d;
`ifdef PREFETCH_BUF_EN
            word_cnt_q  <= word_cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_d_d   = prio_d_q;
        port_d_d   = port_d_q;
        cur_addr_d = cur_addr_q;
        rdata_d    = rdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        strb_d     = 1'b0;
        stop_d     = 1'b0;
        close      = 1'b0;
`ifdef PREFETCH_BUF_EN
        word_cnt_d   = word_cnt_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        deliver      = 1'b0;
        deliver_data = buf_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((i_rq | d_rq) && bus.fl_ready) begin
                    strb_d     = 1'b1;
                    port_d_d   = win_d;
                    cur_addr_d = {win_addr[21:2], 2'b00};
                    if (win_tie) prio_d_d = ~prio_d_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.fl_valid) begin
                    rdata_d = bus.fl_data;
                    i_ack_d = ~port_d_q;
                    d_ack_d = port_d_q;
`ifdef PREFETCH_BUF_EN
                    word_cnt_d = 16'd1;
                    if ((cur_addr_q[21:2] == '1) || ((STREAM_MAX != 0) && (CNT_MAX == 16'd1)))
                        close = 1'b1;
                    else
                        state_d = S_STREAM;
`else
                    close = 1'b1;
`endif
                end
            end
`ifdef PREFETCH_BUF_EN
            S_STREAM: begin
                if (buf_valid_q) begin
                    if (hit_any) begin
                        deliver      = 1'b1;
                        deliver_data = buf_data_q;
                        buf_valid_d  = bus.fl_valid;
                        buf_data_d   = bus.fl_data;
                    end else if (other_req || bus.fl_valid) begin
                        close = 1'b1;
                    end
                end else if (hit_any && bus.fl_valid) begin
                    deliver      = 1'b1;
                    deliver_data = bus.fl_data;
                end else if (other_req) begin
                    close = 1'b1;
                end else if (bus.fl_valid) begin
                    buf_valid_d = 1'b1;
                    buf_data_d  = bus.fl_data;
                end
                if (deliver) begin
                    rdata_d    = deliver_data;
                    i_ack_d    = ~hit_d;
                    d_ack_d    = hit_d;
                    cur_addr_d = next_addr;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (hit_tie) prio_d_d = ~prio_d_q;
                    if (last_word) close = 1'b1;
                end
            end
`endif
            S_STOP: begin
                // fl_ready is only trusted once the stop pulse has been seen by the reader.
                if (!stop_q && bus.fl_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (close) begin
            state_d = S_STOP;
            stop_d  = 1'b1;
`ifdef PREFETCH_BUF_EN
            buf_valid_d = 1'b0;
`endif
        end
    end

    assign bus.i_ack      = i_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.rdata      = rdata_q;
    assign bus.fl_rd_strb = strb_q;
    assign bus.fl_stop    = stop_q;
    assign bus.fl_addr    = cur_addr_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a behavioural SPI flash reader model.
// Build with PREFETCH_BUF_EN defined to also exercise the streaming cases.
module tb_flash_arbiter;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_arbiter_if bus();

    flash_arbiter #(.STREAM_MAX(4), .PRIO_D_INIT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem(input logic [21:0] a);
        if (a == 22'h000104) return 32'hDEADBEEF;
        return 32'hA5000000 | {10'd0, a};
    endfunction

    // Reader model: 32 clk command + 32 clk per word, words repeat until fl_stop.
    int          rd_cnt;
    logic        rd_stream;
    logic [21:0] rd_addr;
    always @(posedge clk) begin
        bus.fl_valid <= 1'b0;
        if (rst) begin
            bus.fl_ready <= 1'b1;
            bus.fl_data  <= '0;
            rd_cnt       <= 0;
            rd_stream    <= 1'b0;
            rd_addr      <= '0;
        end else if (bus.fl_stop) begin
            bus.fl_ready <= 1'b1;
            rd_stream    <= 1'b0;
            rd_cnt       <= 0;
        end else if (bus.fl_rd_strb) begin
            bus.fl_ready <= 1'b0;
            rd_stream    <= 1'b1;
            rd_cnt       <= 64;
            rd_addr      <= bus.fl_addr;
        end else if (rd_stream) begin
            if (rd_cnt == 1) begin
                bus.fl_valid <= 1'b1;
                bus.fl_data  <= mem(rd_addr);
                rd_addr      <= rd_addr + 22'd4;
                rd_cnt       <= 32;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    int          cyc = 0;
    int          n_strb = 0;
    int          n_stop = 0;
    int          n_dual = 0;
    logic [21:0] last_strb_addr = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fl_rd_strb === 1'b1) begin
            n_strb         <= n_strb + 1;
            last_strb_addr <= bus.fl_addr;
        end
        if (bus.fl_stop === 1'b1) n_stop <= n_stop + 1;
        if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) n_dual <= n_dual + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input bit use_d, input logic [21:0] addr,
                           output logic [31:0] data, output int lat, output int at);
        bit found;
        if (use_d) begin
            bus.d_addr = addr;
            bus.d_req  = 1'b1;
        end else begin
            bus.i_addr = addr;
            bus.i_req  = 1'b1;
        end
        lat   = 0;
        found = 1'b0;
        while (!found && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
            found = use_d ? bus.d_ack : bus.i_ack;
        end
        chk("ack_timeout", {31'd0, found}, 32'd1);
        data = bus.rdata;
        at   = cyc;
        if (use_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
    endtask

    task automatic wait_any(output bit is_d, output logic [31:0] data);
        int  lat;
        bit  found;
        lat   = 0;
        found = 1'b0;
        is_d  = 1'b0;
        while (!found && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
            found = bus.i_ack | bus.d_ack;
        end
        chk("tie_ack_timeout", {31'd0, found}, 32'd1);
        is_d = bus.d_ack;
        data = bus.rdata;
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] data;
        int          lat, at, s0, p0;
        bit          is_d;
`ifdef PREFETCH_BUF_EN
        int          a0, a1, a2;
`endif

        bus.i_req  = 1'b0;
        bus.i_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_strb", {31'd0, bus.fl_rd_strb}, 32'd0);
        chk("rst_stop", {31'd0, bus.fl_stop}, 32'd0);
        chk("rst_fl_addr", {10'd0, bus.fl_addr}, 32'd0);
        rst = 1'b0;

        // Single ibus read: new stream latency is 1 + 32 + 32 + 2.
        s0 = n_strb;
        p0 = n_stop;
        do_read(1'b0, 22'h000104, data, lat, at);
        chk("single_latency", lat, 32'd67);
        chk("single_rdata", data, 32'hDEADBEEF);
        chk("single_strb_addr", {10'd0, last_strb_addr}, 32'h00000104);
        chk("single_strb_cnt", n_strb - s0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
`ifndef PREFETCH_BUF_EN
        chk("single_stop_cnt", n_stop - p0, 32'd1);
`endif

        // Simultaneous requests: dbus first after reset, then the pointer favours ibus.
        pulse_rst();
        bus.i_addr = 22'h000200;
        bus.d_addr = 22'h000300;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        wait_any(is_d, data);
        chk("tie1_first_is_d", {31'd0, is_d}, 32'd1);
        chk("tie1_d_rdata", data, mem(22'h000300));
        do_read(1'b0, 22'h000200, data, lat, at);
        chk("tie1_i_rdata", data, mem(22'h000200));
        bus.i_addr = 22'h000400;
        bus.d_addr = 22'h000500;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        wait_any(is_d, data);
        chk("tie2_first_is_d", {31'd0, is_d}, 32'd0);
        chk("tie2_i_rdata", data, mem(22'h000400));
        do_read(1'b1, 22'h000500, data, lat, at);
        chk("tie2_d_rdata", data, mem(22'h000500));

`ifdef PREFETCH_BUF_EN
        // Sequential hits ride one stream; a far address closes it.
        pulse_rst();
        s0 = n_strb;
        p0 = n_stop;
        do_read(1'b0, 22'h000100, data, lat, a0);
        do_read(1'b0, 22'h000104, data, lat, a1);
        chk("seq_rdata_104", data, 32'hDEADBEEF);
        do_read(1'b0, 22'h000108, data, lat, a2);
        chk("seq_rdata_108", data, mem(22'h000108));
        chk("seq_gap_1", a1 - a0, 32'd32);
        chk("seq_gap_2", a2 - a1, 32'd32);
        chk("seq_one_strb", n_strb - s0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("seq_no_stop", n_stop - p0, 32'd0);
        do_read(1'b0, 22'h000200, data, lat, at);
        chk("seq_far_rdata", data, mem(22'h000200));
        chk("seq_far_stop", n_stop - p0, 32'd1);
        chk("seq_far_strb", n_strb - s0, 32'd2);

        // Top of flash: no wrap to 0, so the stream closes right after the ack.
        pulse_rst();
        s0 = n_strb;
        p0 = n_stop;
        do_read(1'b1, 22'h3FFFFC, data, lat, at);
        repeat (2) @(posedge clk);
        #1;
        chk("top_stop", n_stop - p0, 32'd1);
        do_read(1'b1, 22'h000000, data, lat, at);
        chk("top_next_strb", n_strb - s0, 32'd2);
        chk("top_next_addr", {10'd0, last_strb_addr}, 32'd0);
        chk("top_next_rdata", data, mem(22'h000000));

        // STREAM_MAX = 4 closes the stream after the fourth word.
        pulse_rst();
        s0 = n_strb;
        p0 = n_stop;
        for (int k = 0; k < 3; k++) do_read(1'b0, 22'(4 * k), data, lat, at);
        repeat (2) @(posedge clk);
        #1;
        chk("max_open_after_3", n_stop - p0, 32'd0);
        do_read(1'b0, 22'h00000C, data, lat, at);
        repeat (2) @(posedge clk);
        #1;
        chk("max_stop_after_4", n_stop - p0, 32'd1);
        do_read(1'b0, 22'h000010, data, lat, at);
        chk("max_5th_strb", n_strb - s0, 32'd2);
        chk("max_5th_addr", {10'd0, last_strb_addr}, 32'h00000010);
        chk("max_5th_rdata", data, mem(22'h000010));
`endif

        // Reset while waiting for a word: no stop pulse, everything idles.
        pulse_rst();
        p0 = n_stop;
        bus.i_addr = 22'h000080;
        bus.i_req  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.i_req  = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rdata", bus.rdata, 32'd0);
        chk("midrst_fl_addr", {10'd0, bus.fl_addr}, 32'd0);
        chk("midrst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        chk("midrst_strb", {31'd0, bus.fl_rd_strb}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_no_stop", n_stop - p0, 32'd0);
        s0 = n_strb;
        do_read(1'b1, 22'h000040, data, lat, at);
        chk("postrst_latency", lat, 32'd67);
        chk("postrst_strb_addr", {10'd0, last_strb_addr}, 32'h00000040);
        chk("postrst_strb_cnt", n_strb - s0, 32'd1);
        chk("postrst_rdata", data, mem(22'h000040));

        repeat (4) @(posedge clk);
        #1;
        chk("no_dual_ack", n_dual, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
